fetch_mem_ctrl: RTL and testbench

Fetch-stage instruction-memory controller for the pipelined CPU: consumes the fetch address `PCF` driven by the PC register and returns `InstrF` to the F/D boundary. It is the producer of `StallF`, holding the PC register while a multi-cycle instruction-memory access is outstanding. It talks to the instruction memory over a level-request / single-pulse-acknowledge handshake, and discards wrong-path responses after a redirect (`FlushF`).

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_timeout_ctr.sv | 37 +++
 rtl/fetch_mem_ctrl.sv | 117 +++++++++++
 tb/tb_fetch_mem_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU package: fetch FSM state encoding
// and the default instruction-memory timeout.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP,
    ERR
  } fetch_state_t;

  localparam int unsigned FETCH_TIMEOUT = 255;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating access-timeout counter.
// Ports: clk, rst (sync, high), clr, en in; expired out.
module fetch_timeout_ctr
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = FETCH_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && cnt_q != MAX)
      cnt_d = cnt_q + W'(1);
  end

  // fires on the cycle whose increment reaches TIMEOUT
  assign expired = en && (cnt_q >= LAST);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fetch_mem_ctrl.sv
// Fetch-stage instruction-memory controller.
// Ports: CLK, RST, PCF, FlushF in; StallF, InstrF,
// InstrValid, FetchErr out; Imem req/ack handshake.
module fetch_mem_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned SIZE    = 32,
  parameter int unsigned TIMEOUT = FETCH_TIMEOUT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [SIZE-1:0] PCF,
  input  logic            FlushF,
  output logic            StallF,
  output logic [SIZE-1:0] InstrF,
  output logic            InstrValid,
  output logic            FetchErr,
  output logic            ImemReq,
  output logic [SIZE-1:0] ImemAddr,
  input  logic            ImemAck,
  input  logic [SIZE-1:0] ImemRData
);

  fetch_state_t    state_q, state_d;
  logic [SIZE-1:0] addr_q, addr_d;
  logic [SIZE-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            ctr_clr, ctr_en, expired;

  fetch_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_ctr (
    .clk    (CLK),
    .rst    (RST),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    err_d   = err_q;
    ctr_clr = 1'b0;
    ctr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!FlushF) begin
          addr_d  = PCF;
          ctr_clr = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ImemAck) begin
          state_d = IDLE;
          if (!FlushF) begin
            instr_d = ImemRData;
            valid_d = 1'b1;
          end
        end else begin
          ctr_en = 1'b1;
          if (expired) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (FlushF) begin
            state_d = DROP;
          end
        end
      end
      DROP: begin
        if (ImemAck) begin
          state_d = IDLE;
        end else begin
          ctr_en = 1'b1;
          if (expired) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      ERR: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // PC may advance only on a delivered, right-path ack
  assign StallF = !((state_q == WAIT) &&
                    ImemAck && !FlushF);

  assign ImemReq    = (state_q == WAIT) ||
                      (state_q == DROP);
  assign ImemAddr   = addr_q;
  assign InstrF     = instr_q;
  assign InstrValid = valid_q;
  assign FetchErr   = err_q;

endmodule

// File: tb/tb_fetch_mem_ctrl.sv
// Self-checking bench for fetch_mem_ctrl.
// Table-driven vectors plus hand-written corner cases.
module tb_fetch_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcf;
  logic        flush;
  logic        stall;
  logic [31:0] instr;
  logic        ivalid;
  logic        ferr;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_mem_ctrl #(
    .SIZE   (32),
    .TIMEOUT(4)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .PCF       (pcf),
    .FlushF    (flush),
    .StallF    (stall),
    .InstrF    (instr),
    .InstrValid(ivalid),
    .FetchErr  (ferr),
    .ImemReq   (req),
    .ImemAddr  (addr),
    .ImemAck   (ack),
    .ImemRData (rdata)
  );

  typedef struct {
    logic        flush;
    logic        ack;
    logic [31:0] pcf;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic        valid;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               n, act, exp);
    end
  endtask

  task automatic drv(input logic r,
                     input logic f,
                     input logic a,
                     input logic [31:0] p,
                     input logic [31:0] d);
    @(negedge clk);
    rst   = r;
    flush = f;
    ack   = a;
    pcf   = p;
    rdata = d;
    #1;
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_req"},   32'(req),    32'd0);
    chk({n, "_addr"},  addr,        32'd0);
    chk({n, "_instr"}, instr,       32'd0);
    chk({n, "_valid"}, 32'(ivalid), 32'd0);
    chk({n, "_err"},   32'(ferr),   32'd0);
    chk({n, "_stall"}, 32'(stall),  32'd1);
  endtask

  localparam logic [31:0] A1 = 32'hAAAA_0001;
  localparam logic [31:0] B2 = 32'hBBBB_0002;
  localparam logic [31:0] C3 = 32'hCCCC_0003;
  localparam logic [31:0] D4 = 32'hDDDD_0004;
  localparam logic [31:0] E5 = 32'hEEEE_0005;
  localparam logic [31:0] F6 = 32'hF0F0_0006;

  initial begin
    // flush ack pcf rdata | req addr stall valid instr
    tbl[0]  = '{0,0,32'h10,0,  0,32'h00,1,0,0};
    tbl[1]  = '{0,1,32'h10,A1, 1,32'h10,0,0,0};
    tbl[2]  = '{0,0,32'h20,0,  0,32'h10,1,1,A1};
    tbl[3]  = '{0,0,32'h20,0,  1,32'h20,1,0,A1};
    tbl[4]  = '{0,0,32'h20,0,  1,32'h20,1,0,A1};
    tbl[5]  = '{0,0,32'h20,0,  1,32'h20,1,0,A1};
    tbl[6]  = '{0,1,32'h20,B2, 1,32'h20,0,0,A1};
    tbl[7]  = '{0,0,32'h30,0,  0,32'h20,1,1,B2};
    tbl[8]  = '{1,0,32'h40,0,  1,32'h30,1,0,B2};
    tbl[9]  = '{0,0,32'h40,0,  1,32'h30,1,0,B2};
    tbl[10] = '{0,1,32'h40,C3, 1,32'h30,1,0,B2};
    tbl[11] = '{0,0,32'h40,0,  0,32'h30,1,0,B2};
    tbl[12] = '{0,1,32'h40,D4, 1,32'h40,0,0,B2};
    tbl[13] = '{0,0,32'h50,0,  0,32'h40,1,1,D4};
    tbl[14] = '{1,1,32'h60,E5, 1,32'h50,1,0,D4};
    tbl[15] = '{1,0,32'h60,0,  0,32'h50,1,0,D4};
    tbl[16] = '{0,0,32'h60,0,  0,32'h50,1,0,D4};
    tbl[17] = '{0,1,32'h60,F6, 1,32'h60,0,0,D4};
    tbl[18] = '{1,1,32'h70,0,  0,32'h60,1,1,F6};
    tbl[19] = '{1,0,32'h70,0,  0,32'h60,1,0,F6};

    rst = 1'b1; flush = 1'b0; ack = 1'b0;
    pcf = '0; rdata = '0;
    drv(1, 0, 0, 32'h0, 32'h0);
    drv(1, 0, 0, 32'h0, 32'h0);
    chk_reset("rst0");

    for (int i = 0; i < 20; i++) begin
      drv(0, tbl[i].flush, tbl[i].ack,
          tbl[i].pcf, tbl[i].rdata);
      chk($sformatf("v%0d_req", i),
          32'(req), 32'(tbl[i].req));
      chk($sformatf("v%0d_addr", i),
          addr, tbl[i].addr);
      chk($sformatf("v%0d_stall", i),
          32'(stall), 32'(tbl[i].stall));
      chk($sformatf("v%0d_valid", i),
          32'(ivalid), 32'(tbl[i].valid));
      chk($sformatf("v%0d_instr", i),
          instr, tbl[i].instr);
      chk($sformatf("v%0d_err", i),
          32'(ferr), 32'd0);
    end

    // timeout: 4 WAIT cycles with no ack
    drv(0, 0, 0, 32'h80, 32'h0);
    chk("to_idle_req", 32'(req), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      drv(0, 0, 0, 32'h80, 32'h0);
      chk($sformatf("to_w%0d_req", i),
          32'(req), 32'd1);
      chk($sformatf("to_w%0d_addr", i),
          addr, 32'h80);
      chk($sformatf("to_w%0d_err", i),
          32'(ferr), 32'd0);
      chk($sformatf("to_w%0d_stall", i),
          32'(stall), 32'd1);
    end
    drv(0, 0, 1, 32'h80, 32'hDEAD_BEEF);
    chk("to_e1_req",   32'(req),   32'd0);
    chk("to_e1_err",   32'(ferr),  32'd1);
    chk("to_e1_stall", 32'(stall), 32'd1);
    drv(0, 0, 0, 32'h80, 32'h0);
    chk("to_e2_req",   32'(req),    32'd0);
    chk("to_e2_err",   32'(ferr),   32'd1);
    chk("to_e2_valid", 32'(ivalid), 32'd0);
    chk("to_e2_instr", instr,       F6);

    drv(1, 0, 0, 32'h90, 32'h0);
    drv(0, 0, 0, 32'h90, 32'h0);
    chk_reset("rst1");

    // reset during WAIT, then late ack in IDLE
    drv(1, 0, 0, 32'h90, 32'h0);
    chk("mr_req",  32'(req), 32'd1);
    chk("mr_addr", addr,     32'h90);
    drv(0, 0, 1, 32'hA0, 32'h5555_5555);
    chk("mr_idle_req",   32'(req),    32'd0);
    chk("mr_idle_valid", 32'(ivalid), 32'd0);
    chk("mr_idle_stall", 32'(stall),  32'd1);
    drv(0, 0, 0, 32'hA0, 32'h0);
    chk("mr_w_req",   32'(req),    32'd1);
    chk("mr_w_addr",  addr,        32'hA0);
    chk("mr_w_valid", 32'(ivalid), 32'd0);
    chk("mr_w_instr", instr,       32'd0);
    drv(0, 0, 1, 32'hA0, 32'h0000_0077);
    chk("mr_ack_stall", 32'(stall), 32'd0);
    drv(0, 1, 0, 32'hA0, 32'h0);
    chk("mr_valid", 32'(ivalid), 32'd1);
    chk("mr_instr", instr,       32'h77);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
